// File: rtl/time_edit_if.sv
// time_edit_if: button, RTC snapshot and digit write-back signals of the time editor.
interface time_edit_if;
  logic btn_edit, btn_next, btn_up, btn_down;
  logic [47:0] rtc_digits;
  logic [11:0] field_sel;
  logic busy, wr_en, done;
  logic [3:0] wr_addr, wr_data;
  modport master(
    output btn_edit, btn_next, btn_up, btn_down, rtc_digits,
    input field_sel, busy, wr_en, wr_addr, wr_data, done
  );
  modport slave(
    input btn_edit, btn_next, btn_up, btn_down, rtc_digits,
    output field_sel, busy, wr_en, wr_addr, wr_data, done
  );
endinterface

// File: rtl/time_edit_ctrl.sv
// time_edit_ctrl: button-driven RTC digit editor with shadow registers and sequential write-back.
// Define EDIT_TIMEOUT_EN to abort an idle edit session after TIMEOUT_CYCLES cycles.
module time_edit_ctrl #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
) (
  input logic clk,
  input logic reset,
  time_edit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;
  state_t state;
  logic [3:0] prev, btn, edge_v;
  logic [11:0][3:0] shadow;
  logic [3:0] cursor, nxt, cur_val, cur_max, new_val, unit_idx, unit_max;
  logic tens_field;
`ifdef EDIT_TIMEOUT_EN
  logic [31:0] idle_cnt;
`endif
  // Units limits depend on the paired tens digit passed in as tens.
  function automatic logic [3:0] field_max(input logic [3:0] f, input logic [3:0] tens);
    case (f)
      4'd1, 4'd3: field_max = 4'd5;
      4'd5: field_max = 4'd2;
      4'd7: field_max = 4'd3;
      4'd9: field_max = 4'd1;
      4'd4: field_max = tens == 4'd2 ? 4'd3 : 4'd9;
      4'd6: field_max = tens == 4'd3 ? 4'd1 : 4'd9;
      4'd8: field_max = tens == 4'd1 ? 4'd2 : 4'd9;
      default: field_max = 4'd9;
    endcase
  endfunction
  // edge_v bits: {edit, next, up, down}
  always_comb begin
    btn = {bus.btn_edit, bus.btn_next, bus.btn_up, bus.btn_down};
    edge_v = btn & ~prev;
    nxt = cursor == 4'd11 ? 4'd0 : cursor + 4'd1;
    cur_val = shadow[cursor];
    cur_max = field_max(cursor, shadow[{cursor[3:1], 1'b1}]);
    new_val = edge_v[1] ? (cur_val >= cur_max ? 4'd0 : cur_val + 4'd1)
                        : (cur_val == 4'd0 ? cur_max : cur_val - 4'd1);
    tens_field = cursor == 4'd5 || cursor == 4'd7 || cursor == 4'd9;
    unit_idx = {cursor[3:1], 1'b0};
    unit_max = field_max(unit_idx, new_val);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cursor <= '0;
      shadow <= '0;
      prev <= '0;
      bus.field_sel <= '0;
      bus.busy <= 1'b0;
      bus.wr_en <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.done <= 1'b0;
`ifdef EDIT_TIMEOUT_EN
      idle_cnt <= '0;
`endif
    end else begin
      prev <= btn;
      bus.done <= 1'b0;
      case (state)
        IDLE: if (edge_v[3]) begin
          state <= EDIT;
          shadow <= bus.rtc_digits;
          cursor <= '0;
          bus.field_sel <= 12'd1;
          bus.busy <= 1'b1;
        end
        EDIT: begin
          if (edge_v[3]) begin
            state <= COMMIT;
            bus.field_sel <= '0;
            bus.wr_en <= 1'b1;
            bus.wr_addr <= '0;
            bus.wr_data <= shadow[0];
          end else if (edge_v[2]) begin
            cursor <= nxt;
            bus.field_sel <= 12'd1 << nxt;
          end else if (edge_v[1] ^ edge_v[0]) begin
            shadow[cursor] <= new_val;
            if (tens_field && shadow[unit_idx] > unit_max) shadow[unit_idx] <= unit_max;
          end
`ifdef EDIT_TIMEOUT_EN
          if (|edge_v) idle_cnt <= '0;
          else if (idle_cnt == TIMEOUT_CYCLES - 32'd1) begin
            state <= IDLE;
            idle_cnt <= '0;
            bus.field_sel <= '0;
            bus.busy <= 1'b0;
          end else idle_cnt <= idle_cnt + 32'd1;
`endif
        end
        default: if (bus.wr_addr == 4'd11) begin
          state <= IDLE;
          bus.busy <= 1'b0;
          bus.wr_en <= 1'b0;
          bus.wr_addr <= '0;
          bus.wr_data <= '0;
          bus.done <= 1'b1;
        end else begin
          bus.wr_addr <= bus.wr_addr + 4'd1;
          bus.wr_data <= shadow[bus.wr_addr + 4'd1];
        end
      endcase
    end
  end
endmodule

// File: tb/tb_time_edit_ctrl.sv
// tb_time_edit_ctrl: reference-model bench for time_edit_ctrl with directed and random button traffic.
module tb_time_edit_ctrl;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  time_edit_if bus();
  time_edit_ctrl #(.TIMEOUT_CYCLES(TO)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  int checks = 0, fails = 0;
  bit run = 0;
  int m_mode, m_cur, m_widx, m_cnt;
  bit m_done, pe, pn, pu, pd;
  int m_sh[12];
  int wr_log[12];
  int wr_cnt = 0, done_cnt = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int maxv(int f);
    case (f)
      1, 3: return 5;
      5: return 2;
      7: return 3;
      9: return 1;
      4: return m_sh[5] == 2 ? 3 : 9;
      6: return m_sh[7] == 3 ? 1 : 9;
      8: return m_sh[9] == 1 ? 2 : 9;
      default: return 9;
    endcase
  endfunction

  // Reference model: mode 0 idle, 1 edit, 2 commit; outputs derived at compare time.
  always @(posedge clk) begin
    bit ee, en, eu, ed;
    int mx;
    ee = bus.btn_edit & ~pe; en = bus.btn_next & ~pn;
    eu = bus.btn_up & ~pu;   ed = bus.btn_down & ~pd;
    pe = bus.btn_edit; pn = bus.btn_next; pu = bus.btn_up; pd = bus.btn_down;
    m_done = 0;
    if (reset) begin
      m_mode = 0; m_cur = 0; m_widx = 0; m_cnt = 0;
      pe = 0; pn = 0; pu = 0; pd = 0;
      foreach (m_sh[k]) m_sh[k] = 0;
    end else if (m_mode == 0) begin
      if (ee) begin
        m_mode = 1; m_cur = 0; m_cnt = 0;
        foreach (m_sh[k]) m_sh[k] = int'(bus.rtc_digits[4*k +: 4]);
      end
    end else if (m_mode == 1) begin
      if (ee) begin m_mode = 2; m_widx = 0; end
      else if (en) m_cur = (m_cur + 1) % 12;
      else if (eu != ed) begin
        mx = maxv(m_cur);
        m_sh[m_cur] = eu ? (m_sh[m_cur] >= mx ? 0 : m_sh[m_cur] + 1) : (m_sh[m_cur] == 0 ? mx : m_sh[m_cur] - 1);
        if ((m_cur == 5 || m_cur == 7 || m_cur == 9) && m_sh[m_cur-1] > maxv(m_cur - 1))
          m_sh[m_cur-1] = maxv(m_cur - 1);
      end
`ifdef EDIT_TIMEOUT_EN
      if (ee | en | eu | ed) m_cnt = 0;
      else if (m_cnt == TO - 1) begin m_mode = 0; m_cnt = 0; end
      else m_cnt++;
`endif
    end else begin
      if (m_widx == 11) begin m_mode = 0; m_done = 1; end
      else m_widx++;
    end
  end

  always @(negedge clk) if (run) begin
    chk("busy", int'(bus.busy), int'(m_mode != 0));
    chk("field_sel", int'(bus.field_sel), m_mode == 1 ? (1 << m_cur) : 0);
    chk("wr_en", int'(bus.wr_en), int'(m_mode == 2));
    chk("wr_addr", int'(bus.wr_addr), m_mode == 2 ? m_widx : 0);
    chk("wr_data", int'(bus.wr_data), m_mode == 2 ? m_sh[m_widx] : 0);
    chk("done", int'(bus.done), int'(m_done));
    if (bus.wr_en) begin wr_log[bus.wr_addr] = int'(bus.wr_data); wr_cnt++; end
    if (bus.done) done_cnt++;
  end

  task automatic step(bit e, bit n, bit u, bit d);
    @(negedge clk); #1;
    bus.btn_edit = e; bus.btn_next = n; bus.btn_up = u; bus.btn_down = d;
  endtask
  task automatic press(bit e, bit n, bit u, bit d);
    step(e, n, u, d);
    step(0, 0, 0, 0);
  endtask
  task automatic idle(int n);
    repeat (n) step(0, 0, 0, 0);
  endtask
  task automatic commit_and_log;
    foreach (wr_log[k]) wr_log[k] = -1;
    wr_cnt = 0; done_cnt = 0;
    press(1, 0, 0, 0);
    idle(14);
  endtask

  function automatic logic [47:0] rand_rtc();
    int d[12];
    logic [47:0] r;
    foreach (d[k]) d[k] = int'($urandom_range(0, 9));
    d[1] = int'($urandom_range(0, 5)); d[3] = int'($urandom_range(0, 5));
    d[5] = int'($urandom_range(0, 2)); d[4] = int'($urandom_range(0, d[5] == 2 ? 3 : 9));
    d[7] = int'($urandom_range(0, 3)); d[6] = int'($urandom_range(0, d[7] == 3 ? 1 : 9));
    d[9] = int'($urandom_range(0, 1)); d[8] = int'($urandom_range(0, d[9] == 1 ? 2 : 9));
    foreach (d[k]) r[4*k +: 4] = 4'(d[k]);
    return r;
  endfunction

  initial begin
    bit found;
    bus.btn_edit = 0; bus.btn_next = 0; bus.btn_up = 0; bus.btn_down = 0;
    bus.rtc_digits = '0;
    @(posedge clk); #1;
    run = 1;
    reset = 0;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_field_sel", int'(bus.field_sel), 0);
    chk("rst_wr_en", int'(bus.wr_en), 0);
    chk("rst_done", int'(bus.done), 0);
    // Units-of-seconds wrap
    press(1, 0, 0, 0);
    chk("enter_sel", int'(bus.field_sel), 1);
    chk("enter_busy", int'(bus.busy), 1);
    repeat (10) press(0, 0, 1, 0);
    chk("us_after10", m_sh[0], 0);
    repeat (2) press(0, 0, 1, 0);
    commit_and_log;
    chk("us_wrap", wr_log[0], 2);
    chk("write_count", wr_cnt, 12);
    chk("done_count", done_cnt, 1);
    chk("post_busy", int'(bus.busy), 0);
    // Hours clamp: Dh 1->2 pulls Uh 9 down to 3
    bus.rtc_digits = 48'h0000_0019_0000;
    press(1, 0, 0, 0);
    repeat (5) press(0, 1, 0, 0);
    chk("dh_sel", int'(bus.field_sel), 12'h020);
    press(0, 0, 1, 0);
    commit_and_log;
    chk("dh_val", wr_log[5], 2);
    chk("uh_clamp", wr_log[4], 3);
    bus.rtc_digits = 48'h0000_0023_0000;
    press(1, 0, 0, 0);
    repeat (4) press(0, 1, 0, 0);
    press(0, 0, 1, 0);
    commit_and_log;
    chk("uh_wrap", wr_log[4], 0);
    chk("dh_keep", wr_log[5], 2);
    // Months: Dme down 0->1 clamps Ume 5 to 2
    bus.rtc_digits = 48'h0005_0000_0000;
    press(1, 0, 0, 0);
    repeat (9) press(0, 1, 0, 0);
    press(0, 0, 0, 1);
    commit_and_log;
    chk("dme_wrap", wr_log[9], 1);
    chk("ume_clamp", wr_log[8], 2);
    // Simultaneous up+down leaves the digit alone
    bus.rtc_digits = 48'h7;
    press(1, 0, 0, 0);
    press(0, 0, 1, 1);
    commit_and_log;
    chk("updown_same", wr_log[0], 7);
    // Reset on the fifth commit write aborts the sequence
    bus.rtc_digits = rand_rtc();
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #1;
      found = bus.wr_en && bus.wr_addr == 4'd4;
    end
    chk("commit_reach", int'(found), 1);
    reset = 1;
    done_cnt = 0;
    @(negedge clk); #1;
    reset = 0;
    chk("abort_wr_en", int'(bus.wr_en), 0);
    chk("abort_busy", int'(bus.busy), 0);
    idle(15);
    chk("abort_no_done", done_cnt, 0);
`ifdef EDIT_TIMEOUT_EN
    bus.rtc_digits = '0;
    press(1, 0, 0, 0);
    wr_cnt = 0;
    idle(13);
    chk("timeout_still_busy", int'(bus.busy), 1);
    idle(5);
    chk("timeout_idle", int'(bus.busy), 0);
    chk("timeout_no_write", wr_cnt, 0);
`endif
    // Random button traffic against the model
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 11) == 0 ? ~bus.btn_edit : bus.btn_edit,
           $urandom_range(0, 3) == 0 ? ~bus.btn_next : bus.btn_next,
           $urandom_range(0, 2) == 0 ? ~bus.btn_up : bus.btn_up,
           $urandom_range(0, 2) == 0 ? ~bus.btn_down : bus.btn_down);
      bus.rtc_digits = rand_rtc();
      reset = $urandom_range(0, 399) == 0;
    end
    reset = 0;
    idle(20);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/time_edit_ctrl.md
TIME_EDIT_CTRL -- requirements
Module: time_edit_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 32'd500_000_000: idle-cycle count before edit abort (used only with EDIT_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  system clock; all logic updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports btn_edit, btn_next, btn_up, btn_down  input  1 each  debounced, synchronized button levels.
REQ-005 SHALL have port rtc_digits  input  48  current RTC BCD digits; nibble k = field k.
REQ-006 SHALL have port field_sel  output  12  one-hot cursor position; all zero outside EDIT.
REQ-007 SHALL have port busy  output  1  high in EDIT or COMMIT.
REQ-008 SHALL have ports wr_en  output  1, wr_addr  output  4, wr_data  output  4  RTC digit write strobe, field index and BCD value.
REQ-009 SHALL have port done  output  1  one-cycle pulse after the last commit write.
REQ-010 SHALL use field order 0..11 = Us, Ds, Um, Dm, Uh, Dh, Ud, Dd, Ume, Dme, Ua, Da.

Function
REQ-011 SHALL detect rising edges on each button (registered previous level); only edges act.
REQ-012 SHALL apply button priority edit > next > up/down, at most one action per cycle.
REQ-013 SHALL ignore simultaneous up and down edges in the same cycle.
REQ-014 SHALL implement states IDLE, EDIT, COMMIT.
REQ-015 IDLE: edit edge -> EDIT; copy rtc_digits into 12 x 4-bit shadow registers; set cursor to 0.
REQ-016 EDIT: next edge -> cursor+1, wrapping 11 -> 0.
REQ-017 EDIT: up edge -> shadow[cursor]+1, wrapping max -> 0.
REQ-018 EDIT: down edge -> shadow[cursor]-1, wrapping 0 -> max.
REQ-019 SHALL use these field maxima:
- Us, Um, Ua, Da: 9
- Ds, Dm: 5
- Dh: 2; Dd: 3; Dme: 1
- Uh: 3 if Dh==2, else 9
- Ud: 1 if Dd==3, else 9
- Ume: 2 if Dme==1, else 9
REQ-020 On any change to Dh, Dd or Dme, SHALL clamp the paired units digit to its new maximum in the same cycle.
REQ-021 EDIT: edit edge -> COMMIT, with write index cleared to 0.
REQ-022 COMMIT behaviour:
- assert wr_en for exactly 12 consecutive cycles
- wr_addr = 0..11 ascending
- wr_data = shadow[wr_addr]
REQ-023 COMMIT: ignore all button edges.
REQ-024 After wr_addr 11, SHALL return to IDLE and pulse done for exactly 1 cycle.
REQ-025 Write latency: first wr_en in the cycle after the edit edge is registered.
REQ-026 field_sel SHALL equal 1<<cursor in EDIT.

Reset
REQ-027 On reset, SHALL set:
- state IDLE
- cursor 0, shadow all 0, write index 0
- edge registers 0
- field_sel, busy, wr_en, wr_addr, wr_data, done all 0
REQ-028 Reset during COMMIT SHALL abort the write sequence; wr_en is 0 from the next cycle and done is not pulsed.

Configuration
REQ-029 With EDIT_TIMEOUT_EN defined:
- a 32-bit counter runs in EDIT and clears on any button edge
- on reaching TIMEOUT_CYCLES-1, SHALL return to IDLE without writing and without a done pulse
REQ-030 Without EDIT_TIMEOUT_EN, SHALL have no timeout counter and remain in EDIT indefinitely.

Verification
REQ-031 Reset, rtc_digits=0, edit edge, 12 up edges on field 0 -> Us wraps 9 -> 0 after 10 edges, then reads 2.
REQ-032 Hours edit: set Dh=1, Uh=9, then Dh up to 2 -> Uh clamps to 3; further up edge on Uh -> 0.
REQ-033 Down edge on Dme=0 -> Dme=1; with Ume=5 -> Ume clamps to 2.
REQ-034 Edit, next x3, edit -> 12 consecutive wr_en cycles with wr_addr 0..11 and shadow data, then done for 1 cycle, busy low.
REQ-035 Reset asserted at the 5th commit write -> wr_en 0 next cycle, no done, state IDLE.
REQ-036 With EDIT_TIMEOUT_EN and TIMEOUT_CYCLES=16: enter EDIT, no buttons for 16 cycles -> IDLE, no wr_en; same up+down edge -> digit unchanged.
